// File: rtl/chr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : chr_fetch
//  Purpose  : Cartridge character-address fetcher. Synchronises the PCK1B and
//             PCK2B strobes, latches the multiplexed P bus into the C (sprite)
//             and S (fix) address registers, then runs multi-word burst reads
//             from a shared ROM port over a req/ack handshake. Each completed
//             burst is presented as one wide word with a one-cycle valid.
//  Ports    :
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     p_i          multiplexed address bus (CW bits)
//     pck1b_i      C-address strobe, asynchronous, rising edge latches
//     pck2b_i      S-address strobe, asynchronous, rising edge latches
//     sda_i        direct fix-layer address (16 bits)
//     smode_i      0: S address from latched P[15:0]; 1: from sda_i
//     mem_req_o    read request, held with sel/addr until acknowledged
//     mem_sel_o    0 = C ROM, 1 = S ROM
//     mem_addr_o   word address (AW bits)
//     mem_ack_i    request accepted, mem_rdata_i valid this cycle
//     mem_rdata_i  read data (DW bits)
//     cdata_o      C burst, word i at [i*DW +: DW]
//     cvalid_o     one-cycle pulse, cdata_o updated
//     sdata_o      S burst, same packing
//     svalid_o     one-cycle pulse, sdata_o updated
//     overrun_o    sticky lost-address flags: [0] C, [1] S
//  Revision : 1.0 - initial release
// ============================================================================
module chr_fetch #(
   parameter int CW     = 24,
   parameter int DW     = 16,
   parameter int AW     = 26,
   parameter int CBURST = 4,
   parameter int SBURST = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CW-1:0]        p_i,
   input  logic                 pck1b_i,
   input  logic                 pck2b_i,
   input  logic [15:0]          sda_i,
   input  logic                 smode_i,
   output logic                 mem_req_o,
   output logic                 mem_sel_o,
   output logic [AW-1:0]        mem_addr_o,
   input  logic                 mem_ack_i,
   input  logic [DW-1:0]        mem_rdata_i,
   output logic [CBURST*DW-1:0] cdata_o,
   output logic                 cvalid_o,
   output logic [SBURST*DW-1:0] sdata_o,
   output logic                 svalid_o,
   output logic [1:0]           overrun_o
);

   localparam int CLOG = $clog2(CBURST);
   localparam int SLOG = $clog2(SBURST);
   localparam int IW   = (CLOG > SLOG) ? CLOG : SLOG;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CFETCH = 2'd1;
   localparam logic [1:0] ST_SFETCH = 2'd2;

   // ------------------------------------------------------------------------
   // Strobe synchronisers and P bus alignment
   // ------------------------------------------------------------------------
   logic [2:0]    pck1_sync_q;
   logic [2:0]    pck2_sync_q;
   logic [CW-1:0] pd1_q;
   logic [CW-1:0] pd2_q;

   // Two P delay stages: when the rise pulse is seen, pd2_q holds the P value
   // sampled on the same clock that the first synchroniser stage caught the
   // strobe edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pck1_sync_q <= 3'b000;
         pck2_sync_q <= 3'b000;
         pd1_q       <= '0;
         pd2_q       <= '0;
      end else begin
         pck1_sync_q <= {pck1_sync_q[1:0], pck1b_i};
         pck2_sync_q <= {pck2_sync_q[1:0], pck2b_i};
         pd1_q       <= p_i;
         pd2_q       <= pd1_q;
      end
   end

   logic c_rise;
   logic s_rise;
   assign c_rise = pck1_sync_q[1] & ~pck1_sync_q[2];
   assign s_rise = pck2_sync_q[1] & ~pck2_sync_q[2];

   // ------------------------------------------------------------------------
   // FSM: state register / next-state / outputs
   // ------------------------------------------------------------------------
   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic [CW-1:0] ca_q;
   logic [15:0]   sa_q;
   logic          cpend_q;
   logic          spend_q;
   logic [CW-1:0] base_q;
   logic [IW-1:0] idx_q;

   logic c_start;
   logic s_start;
   logic c_last;
   logic s_last;

   // C has priority over S when both are pending in IDLE.
   assign c_start = (state_q == ST_IDLE) && cpend_q;
   assign s_start = (state_q == ST_IDLE) && !cpend_q && spend_q;
   assign c_last  = (state_q == ST_CFETCH) && mem_ack_i && (idx_q == IW'(CBURST-1));
   assign s_last  = (state_q == ST_SFETCH) && mem_ack_i && (idx_q == IW'(SBURST-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cpend_q) begin
               state_d = ST_CFETCH;
            end else if (spend_q) begin
               state_d = ST_SFETCH;
            end
         end
         ST_CFETCH: begin
            if (c_last) begin
               state_d = ST_IDLE;
            end
         end
         ST_SFETCH: begin
            if (s_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request, select and address are pure functions of state, base and idx,
   // so they stay stable until the ack advances idx.
   always_comb begin
      mem_req_o  = 1'b0;
      mem_sel_o  = 1'b0;
      mem_addr_o = '0;
      case (state_q)
         ST_CFETCH: begin
            mem_req_o  = 1'b1;
            mem_addr_o = AW'({base_q, idx_q[CLOG-1:0]});
         end
         ST_SFETCH: begin
            mem_req_o  = 1'b1;
            mem_sel_o  = 1'b1;
            mem_addr_o = AW'({base_q[15:0], idx_q[SLOG-1:0]});
         end
         default: begin
            mem_req_o  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Address latches, pending flags and overrun
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ca_q      <= '0;
         sa_q      <= '0;
         cpend_q   <= 1'b0;
         spend_q   <= 1'b0;
         overrun_o <= 2'b00;
      end else begin
         // A new edge in the same cycle the FSM consumes the pending address
         // re-arms the flag without counting as a lost address.
         if (c_rise) begin
            ca_q    <= pd2_q;
            cpend_q <= 1'b1;
            if (cpend_q && !c_start) begin
               overrun_o[0] <= 1'b1;
            end
         end else if (c_start) begin
            cpend_q <= 1'b0;
         end

         if (s_rise) begin
            sa_q    <= pd2_q[15:0];
            spend_q <= 1'b1;
            if (spend_q && !s_start) begin
               overrun_o[1] <= 1'b1;
            end
         end else if (s_start) begin
            spend_q <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Burst datapath
   // ------------------------------------------------------------------------
   logic [CBURST*DW-1:0] cbuf_q;
   logic [SBURST*DW-1:0] sbuf_q;
   logic [CBURST*DW-1:0] cbuf_d;
   logic [SBURST*DW-1:0] sbuf_d;

   // Buffer contents with the word currently on mem_rdata_i merged in; on
   // the final ack this is the complete burst handed to the output register.
   always_comb begin
      cbuf_d = cbuf_q;
      for (int i = 0; i < CBURST; i++) begin
         if (idx_q == IW'(i)) begin
            cbuf_d[i*DW +: DW] = mem_rdata_i;
         end
      end
   end

   always_comb begin
      sbuf_d = sbuf_q;
      for (int i = 0; i < SBURST; i++) begin
         if (idx_q == IW'(i)) begin
            sbuf_d[i*DW +: DW] = mem_rdata_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q   <= '0;
         idx_q    <= '0;
         cbuf_q   <= '0;
         sbuf_q   <= '0;
         cdata_o  <= '0;
         sdata_o  <= '0;
         cvalid_o <= 1'b0;
         svalid_o <= 1'b0;
      end else begin
         cvalid_o <= c_last;
         svalid_o <= s_last;

         if (c_start) begin
            base_q <= ca_q;
            idx_q  <= '0;
         end else if (s_start) begin
            // The fix source is snapshotted here so a later strobe or sda
            // change cannot disturb the burst in flight.
            base_q <= CW'(smode_i ? sda_i : sa_q);
            idx_q  <= '0;
         end else if (mem_req_o && mem_ack_i) begin
            idx_q  <= idx_q + IW'(1);
         end

         if ((state_q == ST_CFETCH) && mem_ack_i) begin
            cbuf_q <= cbuf_d;
         end
         if ((state_q == ST_SFETCH) && mem_ack_i) begin
            sbuf_q <= sbuf_d;
         end

         if (c_last) begin
            cdata_o <= cbuf_d;
         end
         if (s_last) begin
            sdata_o <= sbuf_d;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_chr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chr_fetch
//  Purpose  : Self-checking bench for chr_fetch. A transaction-level model
//             tracks pending C/S addresses, the burst in flight, expected
//             output words and sticky overrun flags; a compare process checks
//             the DUT against it every cycle. Directed scenarios add literal
//             expectations that pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chr_fetch;

   localparam int CW = 24;
   localparam int DW = 16;
   localparam int AW = 26;
   localparam int CB = 4;
   localparam int SB = 2;

   logic              clk;
   logic              rst_n;
   logic [CW-1:0]     p;
   logic              pck1b;
   logic              pck2b;
   logic [15:0]       sda;
   logic              smode;
   logic              mem_req;
   logic              mem_sel;
   logic [AW-1:0]     mem_addr;
   logic              mem_ack;
   logic [DW-1:0]     mem_rdata;
   logic [CB*DW-1:0]  cdata;
   logic              cvalid;
   logic [SB*DW-1:0]  sdata;
   logic              svalid;
   logic [1:0]        overrun;

   chr_fetch #(.CW(CW), .DW(DW), .AW(AW), .CBURST(CB), .SBURST(SB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .p_i        (p),
      .pck1b_i    (pck1b),
      .pck2b_i    (pck2b),
      .sda_i      (sda),
      .smode_i    (smode),
      .mem_req_o  (mem_req),
      .mem_sel_o  (mem_sel),
      .mem_addr_o (mem_addr),
      .mem_ack_i  (mem_ack),
      .mem_rdata_i(mem_rdata),
      .cdata_o    (cdata),
      .cvalid_o   (cvalid),
      .sdata_o    (sdata),
      .svalid_o   (svalid),
      .overrun_o  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   logic [CW-1:0]    m_pc;
   logic             m_pcv = 1'b0;
   logic [15:0]      m_ps;
   logic             m_psv = 1'b0;
   logic [1:0]       m_ovr = 2'b00;
   logic [CB*DW-1:0] m_cdata = '0;
   logic [SB*DW-1:0] m_sdata = '0;
   logic [CB*DW-1:0] nxt_cdata;
   logic [SB*DW-1:0] nxt_sdata;
   logic             exp_cv = 1'b0;
   logic             exp_sv = 1'b0;
   logic             in_burst = 1'b0;
   logic             just_done = 1'b0;
   logic             bsel;
   int               bbase;
   int               w = 0;
   int               idle_cnt = 0;
   logic [DW-1:0]    col [0:CB-1];
   int               cyc = 0;
   int               n_cv = 0;
   int               n_sv = 0;
   int               req_cyc_c, req_cyc_s, lat_c, last_cv_cyc, last_sv_cyc;
   logic [AW-1:0]    first_addr_c, first_addr_s;

   // stimulus knobs for the ack responder
   int               ack_mode = 0;   // 0 always, 1 every 3rd cycle, 2 never
   logic [DW-1:0]    salt = '0;
   int               cyc_a = 0;

   always @(posedge clk) begin
      #1;
      cyc_a++;
      case (ack_mode)
         0:       mem_ack = 1'b1;
         1:       mem_ack = (cyc_a % 3 == 0);
         default: mem_ack = 1'b0;
      endcase
      mem_rdata = 16'h00A0 + salt + DW'(w);
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         check("rst_req", {mem_req, mem_sel, mem_addr}, '0);
         check("rst_out", {cvalid, svalid, overrun, cdata, sdata}, '0);
         m_pcv = 0; m_psv = 0; m_ovr = 0; m_cdata = '0; m_sdata = '0;
         exp_cv = 0; exp_sv = 0; in_burst = 0; just_done = 0; w = 0; idle_cnt = 0;
      end else begin
         check("cvalid", cvalid, exp_cv);
         if (exp_cv) begin m_cdata = nxt_cdata; n_cv++; lat_c = cyc - req_cyc_c; last_cv_cyc = cyc; end
         check("svalid", svalid, exp_sv);
         if (exp_sv) begin m_sdata = nxt_sdata; n_sv++; last_sv_cyc = cyc; end
         exp_cv = 0; exp_sv = 0;
         check("cdata", cdata, m_cdata);
         check("sdata", sdata, m_sdata);
         check("overrun", overrun, m_ovr);

         if (!in_burst) begin
            if (mem_req) begin
               if (just_done) check("idle_after_burst", 1, 0);
               if (m_pcv) begin
                  in_burst = 1; bsel = 0; bbase = int'(m_pc); m_pcv = 0;
                  first_addr_c = mem_addr; req_cyc_c = cyc;
               end else if (m_psv) begin
                  in_burst = 1; bsel = 1; bbase = smode ? int'(sda) : int'(m_ps); m_psv = 0;
                  first_addr_s = mem_addr; req_cyc_s = cyc;
               end else begin
                  check("spurious_req", 1, 0);
               end
               w = 0; idle_cnt = 0;
            end else if (m_pcv || m_psv) begin
               idle_cnt++;
               if (idle_cnt > 1) check("start_latency", idle_cnt, 1);
            end
         end
         just_done = 0;

         if (in_burst) begin
            int nw;
            nw = bsel ? SB : CB;
            check("mem_req", mem_req, 1);
            check("mem_sel", mem_sel, bsel);
            check("mem_addr", mem_addr, AW'(bbase * nw + w));
            if (mem_req && mem_ack) begin
               col[w] = mem_rdata;
               w++;
               if (w == nw) begin
                  if (bsel) begin
                     nxt_sdata = '0;
                     for (int i = 0; i < SB; i++) nxt_sdata |= (SB*DW)'(col[i]) << (i*DW);
                     exp_sv = 1;
                  end else begin
                     nxt_cdata = '0;
                     for (int i = 0; i < CB; i++) nxt_cdata |= (CB*DW)'(col[i]) << (i*DW);
                     exp_cv = 1;
                  end
                  in_burst = 0; w = 0; just_done = 1;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- driver
   // Strobe pulse: P set a cycle ahead, strobe held high 4 cycles. The model
   // learns of the edge on the clock the DUT latches it.
   task automatic pulse(input logic c, input logic s, input logic [CW-1:0] addr);
      p = addr;
      @(posedge clk); #1;
      pck1b = c; pck2b = s;
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      if (c) begin if (m_pcv) m_ovr[0] = 1'b1; m_pc = addr; m_pcv = 1'b1; end
      if (s) begin if (m_psv) m_ovr[1] = 1'b1; m_ps = addr[15:0]; m_psv = 1'b1; end
      @(posedge clk); #1;
      pck1b = 1'b0; pck2b = 1'b0;
   endtask

   task automatic wait_cv(input int target);
      for (int i = 0; i < 300 && n_cv < target; i++) @(posedge clk);
      #1;
      check("cvalid_timeout", n_cv >= target, 1);
   endtask

   task automatic wait_sv(input int target);
      for (int i = 0; i < 300 && n_sv < target; i++) @(posedge clk);
      #1;
      check("svalid_timeout", n_sv >= target, 1);
   endtask

   initial begin
      rst_n = 1'b0; p = '0; pck1b = 1'b0; pck2b = 1'b0; sda = '0; smode = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_req", mem_req, 0);
      check("reset_cdata", cdata, 0);

      // 1: C burst, zero-wait acks
      ack_mode = 0; salt = 16'h0000;
      pulse(1'b1, 1'b0, 24'h123456);
      wait_cv(1);
      check("t1_addr0", first_addr_c, 26'h048D158);
      check("t1_cdata", cdata, 64'h00A3_00A2_00A1_00A0);
      check("t1_latency", lat_c, 4);
      repeat (4) @(posedge clk); #1;

      // 2: S burst from sda, ack every third cycle
      smode = 1'b1; sda = 16'hBEEF; salt = 16'h0010; ack_mode = 1;
      pulse(1'b0, 1'b1, 24'h777777);
      wait_sv(1);
      check("t2_addr0", first_addr_s, 26'h0017DDE);
      check("t2_sdata", sdata, 32'h00B1_00B0);
      check("t2_cv_count", n_cv, 1);
      smode = 1'b0;
      repeat (4) @(posedge clk); #1;

      // 3: simultaneous edges, C then S
      ack_mode = 0; salt = 16'h0020;
      pulse(1'b1, 1'b1, 24'h00C0DE);
      wait_sv(2);
      check("t3_cv_count", n_cv, 2);
      check("t3_order", last_cv_cyc < last_sv_cyc, 1);
      check("t3_overrun", overrun, 2'b00);
      check("t3_saddr", first_addr_s, 26'h00181BC);
      repeat (4) @(posedge clk); #1;

      // 4: stalled burst, two more edges -> overrun, second address wins
      ack_mode = 2; salt = 16'h0030;
      pulse(1'b1, 1'b0, 24'h000010);
      repeat (4) @(posedge clk); #1;
      pulse(1'b1, 1'b0, 24'h0ABCDE);
      repeat (4) @(posedge clk); #1;
      pulse(1'b1, 1'b0, 24'h0FEDCB);
      repeat (2) @(posedge clk); #1;
      check("t4_overrun", overrun, 2'b01);
      ack_mode = 0;
      wait_cv(4);
      check("t4_addr0", first_addr_c, 26'h03FB72C);
      repeat (4) @(posedge clk); #1;

      // 5: reset in the middle of a C burst
      salt = 16'h0040;
      pulse(1'b1, 1'b0, 24'h00ABCD);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("t5_req_drop", mem_req, 0);
      repeat (3) @(posedge clk); #1;
      check("t5_cdata", cdata, 0);
      check("t5_overrun", overrun, 2'b00);
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      check("t5_no_cvalid", n_cv, 4);
      pulse(1'b1, 1'b0, 24'h654321);
      wait_cv(5);
      check("t5_addr0", first_addr_c, 26'h1950C84);
      check("t5_cdata_new", cdata, 64'h00E3_00E2_00E1_00E0);
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/chr_fetch.md
# chr_fetch

Single-clock successor to the cartridge character-address multiplexer. It synchronises the PCK1B/PCK2B strobes and latches the multiplexed P bus into C (sprite) and S (fix) address registers. It then sequences parametrised multi-word burst reads from a shared ROM port through a req/ack handshake, and presents each completed burst as one wide word with a valid pulse. It sits between the cartridge edge (P bus, strobes, SDA) and the ROM/SDRAM arbiter.

## Interface
- CW, 24: P bus / C address register width
- DW, 16: ROM data word width
- AW, 26: memory address width; must be ≥ CW+log2(CBURST) and ≥ 16+log2(SBURST)
- CBURST, 4: words per C fetch; power of two, ≥2
- SBURST, 2: words per S fetch; power of two, ≥2

- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- p  in  CW  multiplexed address bus
- pck1b  in  1  C-address strobe, asynchronous, rising edge latches
- pck2b  in  1  S-address strobe, asynchronous, rising edge latches
- sda  in  16  direct fix-layer address
- smode  in  1  0: S address from latched P[15:0]; 1: from sda (sampled at S fetch start)
- mem_req  out  1  read request
- mem_sel  out  1  0 = C ROM, 1 = S ROM
- mem_addr  out  AW  word address
- mem_ack  in  1  request accepted, mem_rdata valid this cycle
- mem_rdata  in  DW  read data
- cdata  out  CBURST*DW  C burst; word i at [i*DW +: DW]
- cvalid  out  1  one-cycle pulse, cdata updated
- sdata  out  SBURST*DW  S burst, same packing
- svalid  out  1  one-cycle pulse, sdata updated
- overrun  out  2  sticky: [0] C, [1] S address lost

## Operation
- pck1b, pck2b: 3-flop synchronisers; rise = stage2 & ~stage3. p delayed 2 flops, aligned so the latched value is p sampled at the same clk as stage1 saw the edge.
- Edge on pck1b: ca <= p_d; cpend <= 1. If cpend already 1: overrun[0] <= 1, new value replaces. Same for pck2b/sa/spend/overrun[1].
- FSM states IDLE, CFETCH, SFETCH.
  - IDLE: cpend → CFETCH (priority); else spend → SFETCH. On entry: base <= ca (or S source per smode), pend cleared, idx <= 0. An edge in the entry cycle sets pend again, with no overrun.
  - CFETCH: mem_req=1, mem_sel=0, mem_addr = zero-extended {base, idx[log2(CBURST)-1:0]}. On mem_ack: cbuf[idx] <= mem_rdata, idx++. On the ack with idx==CBURST-1: cdata <= cbuf with final word, cvalid=1 next cycle, → IDLE.
  - SFETCH: likewise with mem_sel=1, mem_addr = zero-extended {base16, idx}, sbuf/sdata/svalid, SBURST.
- mem_req, mem_sel, mem_addr stable until ack; mem_ack while mem_req=0 ignored.
- Latch during a fetch: updates ca/sa and pend only; the in-flight burst uses the snapshot base.
- cdata/sdata hold their value between bursts; partial bursts are never exposed.
- overrun cleared only by reset.

## Timing
- Reset (async assert, sync deassert by the reset tree): state IDLE, all outputs 0, ca/sa/pend/buffers/idx 0, mem_req drops immediately. A reset mid-burst discards the burst without a valid pulse.
- pck rise to pend set: 3 clk. Pend to mem_req high: 1 clk (IDLE→FETCH).
- Zero-wait ack: burst of N words occupies N cycles; cvalid/svalid asserts 1 clk after the final ack; FSM in IDLE that cycle, next fetch mem_req 1 clk later.
- Simultaneous pck1/pck2 edges: both latch; C burst first, S immediately after.
- Strobes must be high ≥3 clk and low ≥3 clk; p must be stable from 1 clk before the rise to 3 clk after.

## Test plan
- Reset, p=0x123456, pck1b rise, ack always 1, rdata=idx+0xA0 → mem_addr 0x48D158..0x48D15B, mem_sel=0, cdata={00A3,00A2,00A1,00A0}, one cvalid pulse 4 clk after mem_req rise.
- smode=1, sda=0xBEEF, pck2b rise, ack every 3rd cycle → mem_addr 0x17DDE,0x17DDF, mem_sel=1, address held across wait cycles, single svalid.
- pck1b and pck2b rise the same clk → full C burst then S burst, no overrun, both valid pulses, C first.
- Two pck1b edges with no fetch in between (mem_ack=0, FSM stalled in CFETCH on a prior burst) → overrun[0]=1, next burst uses the second address.
- rstn low mid-C burst (after 2 acks) → mem_req 0 immediately, no cvalid, cdata 0, FSM IDLE; a following pck1b fetch runs normally.
